// File: rtl/spi_master_arb.sv
// Two-requester SPI master: arbitrates, then shifts one byte MSB-first with a framed 10-period sclk.
// Define SPI_ARB_RR_EN for round-robin arbitration; otherwise req0 has fixed priority.
module spi_master_arb #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0,
   input  logic       req1,
   input  logic [7:0] data0,
   input  logic [7:0] data1,
   output logic       gnt0,
   output logic       gnt1,
   output logic       ack0,
   output logic       ack1,
   output logic       busy,
   output logic       sclk,
   output logic       cs,
   output logic       mosi
);

   typedef enum logic [1:0] {StIdle, StLead, StXfer, StGap} state_e;

   localparam logic [8:0] Div    = 9'(CLK_DIV);
   localparam logic [8:0] DivM1  = 9'(CLK_DIV - 1);
   localparam logic [8:0] GapEnd = 9'(2 * CLK_DIV - 2);

   state_e      state_q, state_d;
   logic [8:0]  cnt_q, cnt_d;
   logic [4:0]  hcnt_q, hcnt_d;
   logic [7:0]  shift_q, shift_d;
   logic        owner_q, owner_d;
   logic        gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic        ack0_q, ack0_d, ack1_q, ack1_d;
   logic        busy_q, busy_d, sclk_q, sclk_d, cs_q, cs_d, mosi_q, mosi_d;
   logic        grant, pick;
`ifdef SPI_ARB_RR_EN
   logic        last_q, last_d;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hcnt_d  = hcnt_q;
      shift_d = shift_q;
      owner_d = owner_q;
      mosi_d  = mosi_q;
      grant   = 1'b0;
      pick    = 1'b0;
`ifdef SPI_ARB_RR_EN
      last_d  = last_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (req0 || req1) begin
               grant = 1'b1;
`ifdef SPI_ARB_RR_EN
               pick   = (req0 && req1) ? ~last_q : req1;
               last_d = pick;
`else
               pick   = ~req0;
`endif
               owner_d = pick;
               shift_d = pick ? data1 : data0;
               state_d = StLead;
               cnt_d   = '0;
            end
         end
         StLead: begin
            if (cnt_q == Div) begin
               state_d = StXfer;
               cnt_d   = '0;
               hcnt_d  = '0;
            end else begin
               cnt_d = cnt_q + 9'd1;
            end
         end
         StXfer: begin
            if (cnt_q == DivM1) begin
               cnt_d = '0;
               if (hcnt_q == 5'd19) state_d = StGap;
               else                 hcnt_d  = hcnt_q + 5'd1;
            end else begin
               cnt_d = cnt_q + 9'd1;
            end
         end
         StGap: begin
            if (cnt_q == GapEnd) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 9'd1;
            end
         end
         default: state_d = StIdle;
      endcase

      // mosi only moves on sclk rising edges; periods 1..8 carry the byte, 0 and 9 are framing
      if (state_d != StXfer) begin
         mosi_d = 1'b0;
      end else if (cnt_d == '0 && !hcnt_d[0]) begin
         if (hcnt_d >= 5'd2 && hcnt_d <= 5'd16) begin
            mosi_d  = shift_q[7];
            shift_d = {shift_q[6:0], 1'b0};
         end else begin
            mosi_d = 1'b0;
         end
      end

      cs_d   = !((state_d == StLead && cnt_d != '0) || state_d == StXfer);
      sclk_d = (state_d == StXfer) && !hcnt_d[0];
      busy_d = (state_d != StIdle);
      gnt0_d = grant && !pick;
      gnt1_d = grant && pick;
      ack0_d = (state_q == StXfer) && (state_d == StGap) && !owner_q;
      ack1_d = (state_q == StXfer) && (state_d == StGap) && owner_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         hcnt_q  <= '0;
         shift_q <= '0;
         owner_q <= 1'b0;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         busy_q  <= 1'b0;
         sclk_q  <= 1'b0;
         cs_q    <= 1'b1;
         mosi_q  <= 1'b0;
`ifdef SPI_ARB_RR_EN
         last_q  <= 1'b1;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hcnt_q  <= hcnt_d;
         shift_q <= shift_d;
         owner_q <= owner_d;
         gnt0_q  <= gnt0_d;
         gnt1_q  <= gnt1_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         busy_q  <= busy_d;
         sclk_q  <= sclk_d;
         cs_q    <= cs_d;
         mosi_q  <= mosi_d;
`ifdef SPI_ARB_RR_EN
         last_q  <= last_d;
`endif
      end
   end

   assign gnt0 = gnt0_q;
   assign gnt1 = gnt1_q;
   assign ack0 = ack0_q;
   assign ack1 = ack1_q;
   assign busy = busy_q;
   assign sclk = sclk_q;
   assign cs   = cs_q;
   assign mosi = mosi_q;

endmodule

// File: tb/tb_spi_master_arb.sv
// Directed bench for spi_master_arb: DUT a at CLK_DIV=2, DUT b at CLK_DIV=1, each with a slave model.
// Arbitration expectations follow SPI_ARB_RR_EN.
module tb_spi_master_arb;

   logic       clk = 1'b0;
   logic       rst_a, req0_a, req1_a, rst_b, req0_b, req1_b;
   logic [7:0] data0_a, data1_a, data0_b, data1_b;
   logic       gnt0_a, gnt1_a, ack0_a, ack1_a, busy_a, sclk_a, cs_a, mosi_a;
   logic       gnt0_b, gnt1_b, ack0_b, ack1_b, busy_b, sclk_b, cs_b, mosi_b;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   spi_master_arb #(.CLK_DIV(2)) u_a (
      .clk(clk), .rst(rst_a), .req0(req0_a), .req1(req1_a), .data0(data0_a), .data1(data1_a),
      .gnt0(gnt0_a), .gnt1(gnt1_a), .ack0(ack0_a), .ack1(ack1_a), .busy(busy_a),
      .sclk(sclk_a), .cs(cs_a), .mosi(mosi_a)
   );

   spi_master_arb #(.CLK_DIV(1)) u_b (
      .clk(clk), .rst(rst_b), .req0(req0_b), .req1(req1_b), .data0(data0_b), .data1(data1_b),
      .gnt0(gnt0_b), .gnt1(gnt1_b), .ack0(ack0_b), .ack1(ack1_b), .busy(busy_b),
      .sclk(sclk_b), .cs(cs_b), .mosi(mosi_b)
   );

   // Slave models: fall 0 arms, falls 1..8 shift in, fall 9 is done
   int         sa_cnt = 0, sb_cnt = 0;
   logic       sa_prev = 1'b0, sb_prev = 1'b0;
   logic [7:0] sa_sh = '0, sb_sh = '0;
   logic [7:0] sa_log[$];
   logic [7:0] sb_log[$];

   always @(negedge clk) begin
      if (cs_a) sa_cnt = 0;
      else if (sa_prev && !sclk_a) begin
         if (sa_cnt >= 1 && sa_cnt <= 8) sa_sh = {sa_sh[6:0], mosi_a};
         if (sa_cnt == 9) sa_log.push_back(sa_sh);
         sa_cnt++;
      end
      sa_prev = sclk_a;
      if (cs_b) sb_cnt = 0;
      else if (sb_prev && !sclk_b) begin
         if (sb_cnt >= 1 && sb_cnt <= 8) sb_sh = {sb_sh[6:0], mosi_b};
         if (sb_cnt == 9) sb_log.push_back(sb_sh);
         sb_cnt++;
      end
      sb_prev = sclk_b;
   end

   task automatic reset_a();
      rst_a = 1'b1;
      @(negedge clk);
      rst_a = 1'b0;
      sa_log.delete();
   endtask

   task automatic test_reset();
      rst_a = 1'b1;
      rst_b = 1'b1;
      @(negedge clk);
      checks++;
      if ({cs_a, sclk_a, mosi_a, gnt0_a, gnt1_a, ack0_a, ack1_a, busy_a} !== 8'b1000_0000) begin
         errors++;
         $display("FAIL reset_a outputs got %b want 10000000",
                  {cs_a, sclk_a, mosi_a, gnt0_a, gnt1_a, ack0_a, ack1_a, busy_a});
      end
      checks++;
      if ({cs_b, sclk_b, mosi_b, gnt0_b, gnt1_b, ack0_b, ack1_b, busy_b} !== 8'b1000_0000) begin
         errors++;
         $display("FAIL reset_b outputs got %b want 10000000",
                  {cs_b, sclk_b, mosi_b, gnt0_b, gnt1_b, ack0_b, ack1_b, busy_b});
      end
      rst_a = 1'b0;
      rst_b = 1'b0;
      sa_log.delete();
      sb_log.delete();
   endtask

   task automatic test_single();
      logic [7:0] exp;
      int         ack_cyc;
      int         k;
      exp     = 8'hA5;
      ack_cyc = -1;
      reset_a();
      data0_a = exp;
      req0_a  = 1'b1;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         checks++;
         if (gnt0_a !== (c == 0) || gnt1_a !== 1'b0) begin
            errors++;
            $display("FAIL single_gnt c=%0d got %b%b want %b0", c, gnt0_a, gnt1_a, c == 0);
         end
         if (c == 0 || c == 1) begin
            checks++;
            if (cs_a !== (c == 0)) begin
               errors++;
               $display("FAIL single_cs c=%0d got %b want %b", c, cs_a, c == 0);
            end
         end
         if (c == 2 || c == 3) begin
            checks++;
            if (sclk_a !== (c == 3)) begin
               errors++;
               $display("FAIL single_sclk c=%0d got %b want %b", c, sclk_a, c == 3);
            end
         end
         if (c >= 3 && c <= 42 && (c - 3) % 4 == 0) begin
            k = (c - 3) / 4;
            checks++;
            if (mosi_a !== ((k >= 1 && k <= 8) ? exp[8-k] : 1'b0)) begin
               errors++;
               $display("FAIL single_mosi P%0d got %b want %b", k, mosi_a,
                        (k >= 1 && k <= 8) ? exp[8-k] : 1'b0);
            end
         end
         if (c == 43) begin
            checks++;
            if (cs_a !== 1'b1 || sclk_a !== 1'b0) begin
               errors++;
               $display("FAIL single_release got cs=%b sclk=%b want cs=1 sclk=0", cs_a, sclk_a);
            end
         end
         if (c == 45 || c == 46) begin
            checks++;
            if (busy_a !== (c == 45)) begin
               errors++;
               $display("FAIL single_busy c=%0d got %b want %b", c, busy_a, c == 45);
            end
         end
         if (ack1_a) begin
            errors++;
            $display("FAIL single_ack1 c=%0d got 1 want 0", c);
         end
         if (ack0_a) begin
            if (ack_cyc >= 0) begin
               errors++;
               $display("FAIL single_ack_repeat c=%0d got second ack want one", c);
            end
            ack_cyc = c;
            req0_a  = 1'b0;
         end
      end
      checks++;
      if (ack_cyc !== 43) begin
         errors++;
         $display("FAIL single_ack_cycle got %0d want 43", ack_cyc);
      end
      checks++;
      if (sa_log.size() != 1 || sa_log[0] !== exp) begin
         errors++;
         $display("FAIL single_slave got %0d bytes first=%h want 1 byte a5", sa_log.size(),
                  sa_log.size() > 0 ? sa_log[0] : 8'hxx);
      end
   endtask

   task automatic test_back_to_back();
      int         exp_c[$];
      int         exp_w[$];
      logic [7:0] exp_rx[$];
      int         got_c[$];
      int         got_w[$];
      int         owner;
`ifdef SPI_ARB_RR_EN
      exp_c  = '{0, 47, 94};
      exp_w  = '{0, 1, 0};
      exp_rx = '{8'h3C, 8'hC3, 8'h3C};
`else
      exp_c  = '{0, 47, 94, 141};
      exp_w  = '{0, 0, 0, 1};
      exp_rx = '{8'h3C, 8'h3C, 8'h3C, 8'hC3};
`endif
      owner = -1;
      reset_a();
      data0_a = 8'h3C;
      data1_a = 8'hC3;
      req0_a  = 1'b1;
      req1_a  = 1'b1;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         checks++;
         if ((gnt0_a && gnt1_a) || (ack0_a && ack1_a)) begin
            errors++;
            $display("FAIL b2b_exclusive c=%0d got gnt=%b%b ack=%b%b want one-hot", c,
                     gnt0_a, gnt1_a, ack0_a, ack1_a);
         end
         if (gnt0_a || gnt1_a) begin
            got_c.push_back(c);
            got_w.push_back(gnt1_a ? 1 : 0);
            owner = gnt1_a ? 1 : 0;
         end
         if (ack0_a || ack1_a) begin
            checks++;
            if ((ack1_a ? 1 : 0) != owner) begin
               errors++;
               $display("FAIL b2b_ack_owner c=%0d got ack%0d want ack%0d", c, ack1_a, owner);
            end
            if (ack1_a) req1_a = 1'b0;
         end
         if (c == 137) begin
            req0_a = 1'b0;
`ifdef SPI_ARB_RR_EN
            req1_a = 1'b0;
`endif
         end
      end
      checks++;
      if (got_c.size() != exp_c.size()) begin
         errors++;
         $display("FAIL b2b_grant_count got %0d want %0d", got_c.size(), exp_c.size());
      end
      for (int i = 0; i < exp_c.size() && i < got_c.size(); i++) begin
         checks++;
         if (got_c[i] != exp_c[i] || got_w[i] != exp_w[i]) begin
            errors++;
            $display("FAIL b2b_grant%0d got gnt%0d@%0d want gnt%0d@%0d", i, got_w[i], got_c[i],
                     exp_w[i], exp_c[i]);
         end
      end
      checks++;
      if (sa_log != exp_rx) begin
         errors++;
         $display("FAIL b2b_slave got %0d bytes want %0d bytes (%p vs %p)", sa_log.size(),
                  exp_rx.size(), sa_log, exp_rx);
      end
   endtask

   task automatic test_reset_mid();
      int gnt_cyc;
      int ack_cyc;
      gnt_cyc = -1;
      ack_cyc = -1;
      reset_a();
      data0_a = 8'hA5;
      req0_a  = 1'b1;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         if (c == 21) begin
            checks++;
            if (cs_a !== 1'b1 || sclk_a !== 1'b0 || busy_a !== 1'b0) begin
               errors++;
               $display("FAIL midrst_abort got cs=%b sclk=%b busy=%b want 1 0 0",
                        cs_a, sclk_a, busy_a);
            end
            rst_a   = 1'b0;
            data0_a = 8'h96;
            sa_log.delete();
         end
         if (c > 0 && gnt0_a && gnt_cyc < 0) gnt_cyc = c;
         if (ack0_a || ack1_a) begin
            if (ack_cyc < 0) ack_cyc = c;
            req0_a = 1'b0;
         end
         if (c == 20) rst_a = 1'b1;
      end
      checks++;
      if (gnt_cyc != 22) begin
         errors++;
         $display("FAIL midrst_regrant got %0d want 22", gnt_cyc);
      end
      checks++;
      if (ack_cyc != 65) begin
         errors++;
         $display("FAIL midrst_ack got first ack at %0d want 65", ack_cyc);
      end
      checks++;
      if (sa_log.size() != 1 || sa_log[0] !== 8'h96) begin
         errors++;
         $display("FAIL midrst_slave got %0d bytes first=%h want 1 byte 96", sa_log.size(),
                  sa_log.size() > 0 ? sa_log[0] : 8'hxx);
      end
   endtask

   task automatic test_drop_req();
      int ack_cyc;
      int extra;
      ack_cyc = -1;
      extra   = 0;
      rst_b   = 1'b1;
      @(negedge clk);
      rst_b = 1'b0;
      sb_log.delete();
      data1_b = 8'hFF;
      req1_b  = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (c == 0) begin
            checks++;
            if (gnt1_b !== 1'b1 || gnt0_b !== 1'b0) begin
               errors++;
               $display("FAIL drop_gnt got gnt=%b%b want 01", gnt0_b, gnt1_b);
            end
         end else if (gnt0_b || gnt1_b) begin
            extra++;
         end
         if (ack0_b) extra++;
         if (ack1_b && ack_cyc < 0) ack_cyc = c;
         if (c == 1) req1_b = 1'b0;
         if (c == 2) data1_b = 8'h00;
      end
      checks++;
      if (ack_cyc != 22) begin
         errors++;
         $display("FAIL drop_ack1 got %0d want 22", ack_cyc);
      end
      checks++;
      if (extra != 0) begin
         errors++;
         $display("FAIL drop_spurious got %0d extra gnt/ack want 0", extra);
      end
      checks++;
      if (sb_log.size() != 1 || sb_log[0] !== 8'hFF) begin
         errors++;
         $display("FAIL drop_slave got %0d bytes first=%h want 1 byte ff", sb_log.size(),
                  sb_log.size() > 0 ? sb_log[0] : 8'hxx);
      end
   endtask

   initial begin
      rst_a = 1'b1; req0_a = 1'b0; req1_a = 1'b0; data0_a = '0; data1_a = '0;
      rst_b = 1'b1; req0_b = 1'b0; req1_b = 1'b0; data0_b = '0; data1_b = '0;
      @(negedge clk);
      test_reset();
      test_single();
      test_back_to_back();
      test_reset_mid();
      test_drop_req();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
